// File: rtl/sample_enable_ctrl.sv
// ----------------------------------------------------------------------------
// sample_enable_ctrl
//
// Runtime-programmable slow-clock enable generator. On start it emits a burst
// of N single-cycle clk_en pulses, D base-clock cycles apart, then raises a
// one-cycle done. Divide ratio D and sample count N can be reprogrammed per
// burst while the controller is idle.
//
// Optional feature macro: SAMPLE_ENABLE_CTRL_CONTINUOUS_EN
//   defined   : cfg_count == 0 selects free-running mode (pulses until abort
//               or rst, sample_idx wraps, no done).
//   undefined : cfg_count == 0 completes immediately (done the cycle after
//               start, no clk_en).
//
// Ports:
//   clk_base    in   base clock, rising edge
//   rst         in   synchronous active-high reset
//   cfg_valid   in   configuration offered
//   cfg_ready   out  configuration accepted (high only in IDLE)
//   cfg_divide  in   divide ratio D (0 is stored as 1)
//   cfg_count   in   samples per burst N
//   start       in   single-cycle burst request
//   abort       in   terminate the current burst
//   busy        out  burst in progress
//   clk_en      out  slow-clock enable pulse
//   ctr         out  phase counter (0 on each clk_en and outside RUN)
//   sample_idx  out  index of the current pulse, valid while clk_en=1
//   done        out  one-cycle burst-complete pulse
// ----------------------------------------------------------------------------
module sample_enable_ctrl #(
    parameter int DIV_W          = 16,
    parameter int CNT_W          = 12,
    parameter int DEFAULT_DIVIDE = 2,
    parameter int DEFAULT_COUNT  = 1
) (
    input  logic             clk_base,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_divide,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             clk_en,
    output logic [DIV_W-1:0] ctr,
    output logic [CNT_W-1:0] sample_idx,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_divide;
    logic [DIV_W-1:0] w_divide_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    // Number of pulses already issued in the current burst.
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_nxt;

    logic             r_clk_en;
    logic             r_done;
    logic             r_busy;
    logic             r_cfg_ready;
    logic [DIV_W-1:0] r_ctr;
    logic [CNT_W-1:0] r_sample_idx;

    logic             w_clk_en_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;
    logic             w_cfg_ready_nxt;
    logic [DIV_W-1:0] w_ctr_nxt;
    logic [CNT_W-1:0] w_idx_nxt;

    logic             w_cfg_acc;
    logic [DIV_W-1:0] w_cfg_div_eff;
    logic             w_tick;
    logic             w_last;
    logic             w_imm_done;

    assign w_cfg_acc     = cfg_valid & r_cfg_ready;
    assign w_cfg_div_eff = (cfg_divide == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg_divide;
    // Full-width compare; r_divide is never 0 so the subtraction cannot wrap.
    assign w_tick        = (r_ctr == (r_divide - DIV_W'(1)));

`ifdef SAMPLE_ENABLE_CTRL_CONTINUOUS_EN
    // Count 0 is free-running: never complete, let r_pcnt wrap freely.
    assign w_last     = r_clk_en & (r_pcnt == r_count) & (r_count != {CNT_W{1'b0}});
    assign w_imm_done = 1'b0;
`else
    logic [CNT_W-1:0] w_burst_cnt;
    // A configuration accepted alongside start applies to that burst.
    assign w_burst_cnt = w_cfg_acc ? cfg_count : r_count;
    assign w_last      = r_clk_en & (r_pcnt == r_count);
    assign w_imm_done  = (w_burst_cnt == {CNT_W{1'b0}});
`endif

    // State and registered outputs.
    always_ff @(posedge clk_base) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_divide     <= DIV_W'(DEFAULT_DIVIDE);
            r_count      <= CNT_W'(DEFAULT_COUNT);
            r_pcnt       <= {CNT_W{1'b0}};
            r_clk_en     <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_ready  <= 1'b1;
            r_ctr        <= {DIV_W{1'b0}};
            r_sample_idx <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_divide     <= w_divide_nxt;
            r_count      <= w_count_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_clk_en     <= w_clk_en_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= w_busy_nxt;
            r_cfg_ready  <= w_cfg_ready_nxt;
            r_ctr        <= w_ctr_nxt;
            r_sample_idx <= w_idx_nxt;
        end
    end

    // Next-state, configuration and pulse-count logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_divide_nxt = r_divide;
        w_count_nxt  = r_count;
        w_pcnt_nxt   = r_pcnt;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_acc) begin
                    w_divide_nxt = w_cfg_div_eff;
                    w_count_nxt  = cfg_count;
                end else begin
                    w_divide_nxt = r_divide;
                    w_count_nxt  = r_count;
                end
                // start beats a simultaneous abort; a zero count never runs.
                if (start && !w_imm_done) begin
                    w_state_nxt = ST_RUN;
                    w_pcnt_nxt  = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_pcnt_nxt = r_pcnt + CNT_W'(1);
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_clk_en_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_ctr_nxt    = {DIV_W{1'b0}};
        w_idx_nxt    = r_sample_idx;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_idx_nxt  = {CNT_W{1'b0}};
                    w_done_nxt = w_imm_done;
                end else begin
                    w_idx_nxt = r_sample_idx;
                end
            end
            ST_RUN: begin
                // abort outranks both completion and a due pulse.
                if (abort) begin
                    w_clk_en_nxt = 1'b0;
                end else if (w_last) begin
                    w_done_nxt = 1'b1;
                end else if (w_tick) begin
                    w_clk_en_nxt = 1'b1;
                    w_idx_nxt    = r_pcnt;
                end else begin
                    w_ctr_nxt = r_ctr + DIV_W'(1);
                end
            end
            default: begin
                w_clk_en_nxt = 1'b0;
            end
        endcase
        w_busy_nxt      = (w_state_nxt == ST_RUN);
        w_cfg_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    assign clk_en     = r_clk_en;
    assign done       = r_done;
    assign busy       = r_busy;
    assign cfg_ready  = r_cfg_ready;
    assign ctr        = r_ctr;
    assign sample_idx = r_sample_idx;

endmodule

// File: tb/tb_sample_enable_ctrl.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for sample_enable_ctrl (default parameters).
// Cycle numbering: cycle 0 is the first cycle after reset is released; inputs
// set in cycle c are sampled at the edge ending c, outputs are read 1 time
// unit after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sample_enable_ctrl;

    logic        clk_base = 1'b0;
    logic        rst      = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_divide = 16'd0;
    logic [11:0] cfg_count  = 12'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        clk_en;
    logic [15:0] ctr;
    logic [11:0] sample_idx;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    sample_enable_ctrl dut (
        .clk_base   (clk_base),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_divide (cfg_divide),
        .cfg_count  (cfg_count),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .clk_en     (clk_en),
        .ctr        (ctr),
        .sample_idx (sample_idx),
        .done       (done)
    );

    always #5 clk_base = ~clk_base;

    task automatic tick();
        @(posedge clk_base);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy,   32'd0);
        chk({tag, "_ready"}, cfg_ready, 32'd1);
        chk({tag, "_en"},    clk_en, 32'd0);
        chk({tag, "_done"},  done,   32'd0);
        chk({tag, "_ctr"},   ctr,    32'd0);
    endtask

    // Caller has start (and optionally cfg) set in cycle t. Checks cycles
    // t+1 .. t+2+N*D and returns in the done cycle. Pulse k at t+1+(k+1)*D.
    task automatic burst(input int d, input int n, input string tag);
        int last_k;
        last_k = n * d + 2;
        for (int k = 1; k <= last_k; k++) begin
            tick();
            if (k == 1) begin
                start = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
            end
            chk({tag, "_busy"},  busy,      (k <= n * d + 1) ? 32'd1 : 32'd0);
            chk({tag, "_ready"}, cfg_ready, (k <= n * d + 1) ? 32'd0 : 32'd1);
            chk({tag, "_done"},  done,      (k == last_k) ? 32'd1 : 32'd0);
            chk({tag, "_en"},    clk_en,
                (k > 1 && k <= n * d + 1 && ((k - 1) % d) == 0) ? 32'd1 : 32'd0);
            chk({tag, "_ctr"},   ctr,       (k <= n * d + 1) ? 32'((k - 1) % d) : 32'd0);
            if (k > 1 && k <= n * d + 1 && ((k - 1) % d) == 0)
                chk({tag, "_idx"}, sample_idx, 32'((k - 1) / d - 1));
        end
    endtask

    initial begin
        // Reset values.
        tick();
        tick();
        chk_idle("rst");
        chk("rst_idx", sample_idx, 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Defaults D=2, N=1, start at cycle 10.
        while (cyc < 10) tick();
        chk_idle("idle10");
        start = 1'b1;
        burst(2, 1, "dflt");

        // D=4, N=3 with start at cycle 30; abort together with start (start wins).
        while (cyc < 30) tick();
        cfg_valid = 1'b1; cfg_divide = 16'd4; cfg_count = 12'd3;
        start = 1'b1; abort = 1'b1;
        burst(4, 3, "d4n3");

        // D=0 stored as 1, N=5; back-to-back restart in the done cycle.
        tick();
        cfg_valid = 1'b1; cfg_divide = 16'd0; cfg_count = 12'd5;
        start = 1'b1;
        burst(1, 5, "d1n5");
        start = 1'b1;
        burst(1, 5, "d1b2b");

        // abort in IDLE has no effect.
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("idleabort");

        // D=4, N=3, abort 8 cycles after start: only pulse 0 appears.
        cfg_valid = 1'b1; cfg_divide = 16'd4; cfg_count = 12'd3;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            start = 1'b0; cfg_valid = 1'b0;
            chk("ab_busy", busy, 32'd1);
            chk("ab_en", clk_en, (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) chk("ab_idx", sample_idx, 32'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab_after");
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("ab_nodone", done, 32'd0);
            chk("ab_noen", clk_en, 32'd0);
        end

        // cfg_valid held through a burst: refused until the done cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_valid = 1'b1; cfg_divide = 16'd3; cfg_count = 12'd2;
        for (int k = 2; k <= 13; k++) begin
            tick();
            chk("hold_ready", cfg_ready, 32'd0);
            chk("hold_en", clk_en, (k == 5 || k == 9 || k == 13) ? 32'd1 : 32'd0);
        end
        tick();
        chk("hold_done", done, 32'd1);
        chk("hold_ready_dn", cfg_ready, 32'd1);
        // Accepted now; the restart must run with D=3, N=2.
        start = 1'b1;
        burst(3, 2, "newcfg");

        // Reset mid-burst, then defaults must be back.
        start = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midrst");
        chk("midrst_idx", sample_idx, 32'd0);
        start = 1'b1;
        burst(2, 1, "postrst");

        // N=0 with D=2.
        tick();
        cfg_valid = 1'b1; cfg_divide = 16'd2; cfg_count = 12'd0;
        start = 1'b1;
        tick();
        start = 1'b0; cfg_valid = 1'b0;
`ifdef SAMPLE_ENABLE_CTRL_CONTINUOUS_EN
        chk("n0_busy", busy, 32'd1);
        for (int k = 2; k <= 12; k++) begin
            tick();
            chk("n0_en", clk_en, ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
            if ((k - 1) % 2 == 0) chk("n0_idx", sample_idx, 32'((k - 1) / 2 - 1));
            chk("n0_done", done, 32'd0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("n0_abort");
`else
        chk("n0_done", done, 32'd1);
        chk("n0_busy", busy, 32'd0);
        chk("n0_en", clk_en, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_idle("n0_after");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
